n_memory: RTL and testbench
===========================

Name: n_memory

Overview:
- Byte-addressed, little-endian 32-bit word memory with a fixed multi-cycle access latency and a 3-bit status output.
- Instantiated twice in the MIPS single-cycle system:
  - Instruction memory: read tied high, write tied low, addr = PC.
  - Data memory: driven by the CPU's MemRead/MemWrite, write data and ALU address.
- The CPU stalls until the status output reports a completed access.

Parameters:
- MEM_BYTES, 1024, number of bytes in the storage array (power of two).
- LATENCY, 2, cycles between accepting a request and completing it (must be >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- read  input  1  read request.
- write  input  1  write request.
- wdata  input  32  write data.
- addr  input  32  byte address of the word.
- rdata  output  32  read data.
- state  output  3  access status.

Behaviour:
- Storage:
  - reg [7:0] mem_array[0:MEM_BYTES-1], hierarchically visible under exactly that name so the bench can preload it with $readmemh (one byte per line, two hex digits).
  - The array is never cleared by rst; preload happens while rst is high.
- Addressing:
  - Effective byte index a = addr mod MEM_BYTES, taken from the low bits.
  - Word bytes are a, a+1, a+2, a+3, each also mod MEM_BYTES, so a word at the top of the array wraps to index 0.
  - No alignment check.
- Little endian:
  - rdata = {m[a+3], m[a+2], m[a+1], m[a]}.
  - A write stores wdata[7:0] at a and wdata[31:24] at a+3.
- State encoding: 0 IDLE, 1 READING, 2 READ_DONE, 3 WRITING, 4 WRITE_DONE. Values 5-7 are unused and fall back to IDLE.
- IDLE:
  - On a rising edge with write=1, latch addr and wdata, clear the counter, go to WRITING.
  - Else, with read=1, latch addr and go to READING.
  - write has priority when both are high.
- READING / WRITING:
  - The counter increments each cycle.
  - On the LATENCY-th edge after acceptance, perform the access using the latched addr/wdata and go to the matching DONE state.
  - Request inputs are ignored while busy; input changes have no effect.
- READ_DONE:
  - rdata holds the new word for exactly one cycle in this state, then the block returns to IDLE.
  - rdata keeps its value until the next read completes; writes never alter rdata.
- WRITE_DONE: the array is updated at the edge entering this state; lasts one cycle, then IDLE.
- Throughput: with read held high, one read completes every LATENCY+2 cycles (IDLE, busy×LATENCY, DONE).
- Reset (asynchronous, any time):
  - state=0, rdata=0, counter=0.
  - A pending write is aborted with the array unchanged; a pending read is discarded.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. Preload bytes 00:78 01:56 02:34 03:12; read=1, addr=0 -> state goes 0,1,1,2 over successive edges; in state 2, rdata=32'h12345678.
2. Write 32'hDEADBEEF at addr=8 -> state reaches 4; then a read of addr 8 returns 32'hDEADBEEF; bytes at 8..11 are EF, BE, AD, DE.
3. read=1, write=1, addr=16, wdata=32'hA5A5A5A5 in IDLE -> state goes to 3 (write wins); rdata unchanged; a later read of 16 returns 32'hA5A5A5A5.
4. Wrap-around: write 32'h11223344 at addr=MEM_BYTES-2 -> bytes 44 and 33 at the top two locations, 22 and 11 at indices 0 and 1. addr=MEM_BYTES+4 aliases to index 4.
5. Assert rst during WRITING -> state=0 and rdata=0 immediately without waiting for a clock edge; the target bytes keep their old values; preloaded contents survive.
6. Hold read=1 and step addr 0, 4, 8, with a new addr applied each time state=2 -> exactly one READ_DONE per LATENCY+2 cycles; each rdata matches its preloaded word.

Source files
------------

// File: rtl/n_memory.sv
// Byte-addressed little-endian 32-bit word memory with a fixed multi-cycle
// access latency and a 3-bit status output (IDLE/READING/READ_DONE/WRITING/WRITE_DONE).
module n_memory #(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] wdata,
  input  logic [31:0] addr,
  output logic [31:0] rdata,
  output logic [2:0]  state
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READING    = 3'd1,
    READ_DONE  = 3'd2,
    WRITING    = 3'd3,
    WRITE_DONE = 3'd4
  } state_e;

  logic [7:0] mem_array [0:MEM_BYTES-1];

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          busy_last;
  logic          mem_we;
  logic          rd_load;

  // Only the low address bits select a byte; the rest alias.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^addr[31:AW];

  // Byte lanes of the latched word; AW-bit arithmetic wraps at the array top.
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  assign idx0 = addr_q;
  assign idx1 = addr_q + AW'(1);
  assign idx2 = addr_q + AW'(2);
  assign idx3 = addr_q + AW'(3);

  assign busy_last = (cnt_q == CW'(LATENCY - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (write) begin
            addr_q  <= addr[AW-1:0];
            wdata_q <= wdata;
          end else if (read) begin
            addr_q <= addr[AW-1:0];
          end
        end
        READING, WRITING: cnt_q <= cnt_q + CW'(1);
        default:          cnt_q <= '0;
      endcase
      if (rd_load) begin
        rdata_q <= {mem_array[idx3], mem_array[idx2], mem_array[idx1], mem_array[idx0]};
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive rst so a preload
  // done while rst is high is kept, and an aborted write leaves it untouched.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_array[idx0] <= wdata_q[7:0];
      mem_array[idx1] <= wdata_q[15:8];
      mem_array[idx2] <= wdata_q[23:16];
      mem_array[idx3] <= wdata_q[31:24];
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (write)     state_d = WRITING;
        else if (read) state_d = READING;
        else           state_d = IDLE;
      end
      READING: state_d = busy_last ? READ_DONE : READING;
      WRITING: state_d = busy_last ? WRITE_DONE : WRITING;
      default: state_d = IDLE;
    endcase
  end

  // The access itself fires on the edge that leaves the last busy cycle.
  always_comb begin
    mem_we  = 1'b0;
    rd_load = 1'b0;
    case (state_q)
      READING: rd_load = busy_last;
      WRITING: mem_we  = busy_last;
      default: ;
    endcase
  end

  assign state = state_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_n_memory.sv
// Self-checking bench for n_memory: a byte-level reference model supplies
// expected words, queued when a read is issued and compared on READ_DONE.
module tb_n_memory;

  localparam int MEM_BYTES = 1024;
  localparam int LATENCY   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        read;
  logic        write;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic [2:0]  state;

  n_memory #(.MEM_BYTES(MEM_BYTES), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .rst   (rst),
    .read  (read),
    .write (write),
    .wdata (wdata),
    .addr  (addr),
    .rdata (rdata),
    .state (state)
  );

  always #5 clk = ~clk;

  logic [7:0]  model_mem [MEM_BYTES];
  logic [31:0] sb [$];
  logic [31:0] last_rd;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = model_mem[(a + 32'(i)) % MEM_BYTES];
    return w;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) model_mem[(a + 32'(i)) % MEM_BYTES] = d[8*i +: 8];
  endtask

  task automatic pop_compare(input string tag);
    logic [31:0] exp;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sb.pop_front();
      check(tag, rdata, exp);
      last_rd = exp;
    end
  endtask

  task automatic run_read(input logic [31:0] a, input logic [31:0] exp);
    sb.push_back(exp);
    read = 1'b1;
    addr = a;
    tick(); check("rd_accept", state, 32'd1);
    for (int i = 1; i < LATENCY; i++) begin
      tick(); check("rd_busy", state, 32'd1);
    end
    tick(); check("rd_done", state, 32'd2);
    read = 1'b0;
    pop_compare("rd_data");
    tick(); check("rd_idle", state, 32'd0);
  endtask

  task automatic run_write(input logic [31:0] a, input logic [31:0] d, input logic with_read);
    write = 1'b1;
    read  = with_read;
    addr  = a;
    wdata = d;
    tick(); check("wr_accept", state, 32'd3);
    write = 1'b0;
    read  = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    for (int i = 1; i < LATENCY; i++) begin
      tick(); check("wr_busy", state, 32'd3);
    end
    tick(); check("wr_done", state, 32'd4);
    model_store(a, d);
    check("wr_rdata_kept", rdata, last_rd);
    tick(); check("wr_idle", state, 32'd0);
  endtask

  initial begin
    logic [31:0] prev_done;
    int          n_done;
    logic [31:0] tp_addr [3];

    rst = 1'b1; read = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    last_rd = 32'h0;

    // Preload while held in reset.
    for (int i = 0; i < MEM_BYTES; i++) begin
      model_mem[i] = 8'($urandom);
      dut.mem_array[i] = model_mem[i];
    end
    model_mem[0] = 8'h78; model_mem[1] = 8'h56; model_mem[2] = 8'h34; model_mem[3] = 8'h12;
    for (int i = 0; i < 4; i++) dut.mem_array[i] = model_mem[i];

    repeat (2) tick();
    check("rst_state", state, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_state", state, 32'd0);

    // Plain read of the preloaded word.
    run_read(32'd0, 32'h12345678);

    // Write then read back, checking byte order in the array.
    run_write(32'd8, 32'hDEADBEEF, 1'b0);
    check("wr_b8",  dut.mem_array[8],  32'hEF);
    check("wr_b9",  dut.mem_array[9],  32'hBE);
    check("wr_b10", dut.mem_array[10], 32'hAD);
    check("wr_b11", dut.mem_array[11], 32'hDE);
    run_read(32'd8, 32'hDEADBEEF);

    // Write wins over a simultaneous read.
    run_write(32'd16, 32'hA5A5A5A5, 1'b1);
    run_read(32'd16, 32'hA5A5A5A5);

    // Wrap-around at the top of the array, then aliasing above MEM_BYTES.
    run_write(32'(MEM_BYTES - 2), 32'h11223344, 1'b0);
    check("wrap_top2", dut.mem_array[MEM_BYTES-2], 32'h44);
    check("wrap_top1", dut.mem_array[MEM_BYTES-1], 32'h33);
    check("wrap_b0",   dut.mem_array[0],           32'h22);
    check("wrap_b1",   dut.mem_array[1],           32'h11);
    run_read(32'(MEM_BYTES - 2), 32'h11223344);
    run_read(32'(MEM_BYTES + 4), model_word(32'd4));

    // Asynchronous reset in the middle of a write.
    write = 1'b1; addr = 32'd40; wdata = ~model_word(32'd40);
    tick(); check("abort_accept", state, 32'd3);
    write = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_state", state, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    last_rd = 32'h0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("abort_idle", state, 32'd0);
    for (int i = 0; i < 4; i++) check("abort_bytes", dut.mem_array[40+i], model_mem[40+i]);
    check("survive_b2", dut.mem_array[2], 32'h34);

    // Back-to-back reads with read held high.
    tp_addr[0] = 32'd0; tp_addr[1] = 32'd4; tp_addr[2] = 32'd8;
    n_done = 0;
    prev_done = 0;
    read = 1'b1;
    addr = tp_addr[0];
    sb.push_back(model_word(tp_addr[0]));
    for (int c = 0; c < 100 && n_done < 3; c++) begin
      tick();
      if (state == 3'd2) begin
        pop_compare("tp_data");
        if (n_done > 0) check("tp_period", 32'(cyc) - prev_done, 32'(LATENCY + 2));
        prev_done = 32'(cyc);
        n_done++;
        if (n_done < 3) begin
          addr = tp_addr[n_done];
          sb.push_back(model_word(tp_addr[n_done]));
        end else begin
          read = 1'b0;
        end
      end
    end
    check("tp_done_count", 32'(n_done), 32'd3);
    check("sb_drained", 32'(sb.size()), 32'd0);
    tick();
    check("tp_idle", state, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
